// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_divider_pkg
// Purpose : Shared definitions for the sequential restoring divider:
//           FSM state encoding and default operand width.
// Ports   : (package - no ports)
// Revision: 1.0 - initial release
// ============================================================================
package seq_divider_pkg;

  // Default operand width of the divider.
  localparam int c_DEFAULT_N = 4;

  // Divider control states, explicitly 2 bits wide.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage : seq_divider_pkg
`default_nettype wire

// File: rtl/seq_divider_adder.sv
`default_nettype none
// ============================================================================
// Module  : seq_divider_adder
// Purpose : W-bit ripple-style adder with carry in/out. The divider feeds it
//           the inverted divisor with carry-in 1, so the adder computes a
//           two's-complement subtraction. Carry-out then means "no borrow".
// Ports   : i_a    [W-1:0] - first operand
//           i_b    [W-1:0] - second operand
//           i_cin          - carry in
//           o_sum  [W-1:0] - sum
//           o_cout         - carry out
// Revision: 1.0 - initial release
// ============================================================================
module seq_divider_adder
  import seq_divider_pkg::*;
#(
  parameter int W = c_DEFAULT_N + 1
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
  assign o_sum  = w_full[W-1:0];
  assign o_cout = w_full[W];

endmodule : seq_divider_adder
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module  : seq_divider
// Purpose : Unsigned N-bit sequential restoring divider. One quotient bit is
//           resolved per clock while busy. A zero divisor skips the
//           iteration entirely and reports quotient all-ones,
//           remainder = dividend and div_by_zero = 1.
// Ports   : clk          - clock, rising edge
//           rst_n        - asynchronous active-low reset
//           start        - request a division (accepted when not busy)
//           dividend [N] - unsigned numerator, sampled on acceptance
//           divisor  [N] - unsigned denominator, sampled on acceptance
//           busy         - high while iterating
//           done         - one-cycle pulse, results valid
//           quotient [N] - unsigned quotient
//           remainder[N] - unsigned remainder
//           div_by_zero  - last accepted divisor was zero
// Revision: 1.0 - initial release
// ============================================================================
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = c_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int             c_CNT_W    = $clog2(N + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(N);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(1);

  state_t             r_state;
  logic [N-1:0]       r_q;        // dividend shifts out of the top, quotient bits shift in
  logic [N-1:0]       r_rem;      // partial remainder
  logic [N-1:0]       r_divisor;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;

  logic [N:0]         w_shift;
  logic [N:0]         w_trial;
  logic               w_nonneg;
  logic               w_unused_trial_msb;

  // R' = {R, Q[N-1]}
  assign w_shift = {r_rem, r_q[N-1]};

  // R' - divisor computed as R' + ~{0,divisor} + 1; carry-out = no borrow.
  seq_divider_adder #(
    .W (N + 1)
  ) u_trial_sub (
    .i_a    (w_shift),
    .i_b    (~{1'b0, r_divisor}),
    .i_cin  (1'b1),
    .o_sum  (w_trial),
    .o_cout (w_nonneg)
  );

  // A kept trial is always below the divisor, so its MSB is always zero.
  assign w_unused_trial_msb = w_trial[N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_q       <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_divisor <= divisor;
            r_cnt     <= c_CNT_INIT;
            if (divisor == '0) begin
              // Zero divisor: produce the defined result immediately.
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_q     <= '1;
              r_rem   <= dividend;
              r_dbz   <= 1'b1;
            end else begin
              r_state <= S_CALC;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_q     <= dividend;
              r_rem   <= '0;
              r_dbz   <= 1'b0;
            end
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end

        S_CALC: begin
          // start is deliberately ignored here.
          r_rem <= w_nonneg ? w_trial[N-1:0] : w_shift[N-1:0];
          r_q   <= {r_q[N-2:0], w_nonneg};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == c_CNT_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_q;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule : seq_divider
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_divider
// Purpose : Self-checking bench for seq_divider (N = 4). Stimulus pushes the
//           hand-computed result onto a queue; a monitor pops and compares on
//           every done pulse.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  localparam int N = 4;

  typedef struct {
    int q;
    int r;
    int dbz;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && done) check("busy_done_exclusive", 1, 0);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("quotient", int'(quotient), e.q);
          check("remainder", int'(remainder), e.r);
          check("div_by_zero", int'(div_by_zero), e.dbz);
        end
      end
    end
  end

  // Drive one request at a negedge; it is accepted on the next posedge.
  task automatic issue(input int a, input int b, input int eq, input int er,
                       input int edbz, input bit hold);
    @(negedge clk);
    start    = 1'b1;
    dividend = N'(a);
    divisor  = N'(b);
    sb.push_back('{q: eq, r: er, dbz: edbz});
    @(posedge clk);
    #1;
    if (!hold) begin
      start    = 1'b0;
      // Scramble inputs: the running operation must not see them.
      dividend = N'($urandom);
      divisor  = N'($urandom);
    end
  endtask

  // Wait (bounded) for done, counting busy cycles seen on the way.
  task automatic wait_done(input int exp_busy);
    int  nbusy = 0;
    bit  found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        break;
      end
      if (busy) nbusy++;
    end
    check("done_seen", int'(found), 1);
    check("busy_cycles", nbusy, exp_busy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #3;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_outputs", int'({quotient, remainder, div_by_zero}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic
    issue(13, 4, 3, 1, 0, 1'b0);
    wait_done(4);

    // Boundaries, with a hold check after one of them
    issue(15, 1, 15, 0, 0, 1'b0);
    wait_done(4);
    @(negedge clk);
    check("hold_done_low", int'(done), 0);
    check("hold_quotient", int'(quotient), 15);
    check("hold_remainder", int'(remainder), 0);
    issue(3, 9, 0, 3, 0, 1'b0);
    wait_done(4);
    issue(0, 5, 0, 0, 0, 1'b0);
    wait_done(4);
    issue(15, 15, 1, 0, 0, 1'b0);
    wait_done(4);
    issue(12, 7, 1, 5, 0, 1'b0);
    wait_done(4);

    // Divide by zero: done on the first edge, no busy, flag holds
    issue(7, 0, 15, 7, 1, 1'b0);
    wait_done(0);
    @(negedge clk);
    check("dbz_hold", int'(div_by_zero), 1);
    check("dbz_hold_remainder", int'(remainder), 7);

    // Busy protection: a start during CALC is ignored
    issue(13, 4, 3, 1, 0, 1'b0);
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd9;
    divisor  = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(3);
    issue(9, 3, 3, 0, 0, 1'b0);
    wait_done(4);

    // Reset abort during the second CALC cycle
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_outputs", int'({quotient, remainder, div_by_zero}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);  // monitor flags any stray done here
    check("abort_idle_busy", int'(busy), 0);
    issue(14, 5, 2, 4, 0, 1'b0);
    wait_done(4);

    // Back-to-back: start held across DONE
    issue(13, 4, 3, 1, 0, 1'b1);
    dividend = 4'd14;
    divisor  = 4'd5;
    sb.push_back('{q: 2, r: 4, dbz: 0});
    wait_done(4);
    @(negedge clk);
    check("b2b_no_gap_busy", int'(busy), 1);
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    wait_done(3);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seq_divider
`default_nettype wire
